sram_chip_model: RTL
====================

// Module: sram_chip_model
// PURPOSE
// Cycle-accurate responder model of the 16-bit asynchronous board SRAM (256K x 16). It sits on the far side
// of the SRAM_* pin bus driven by the memory-stage SRAM controller, in the testbench and the integrated sim top.
// It stores written halfwords and returns read data on SRAM_DQ with a configurable latency.
// It also counts accesses and flags bus-protocol violations, so controller and cache-refill sequencing can be checked.
// PARAMETERS
// ADDR_W     18        address width in halfwords
// DEPTH      262144    implemented words; must be <= 2**ADDR_W
// READ_LAT   0         0 = combinational (async) read; N>=1 = data valid N clk edges after address sampled
// INIT_FILE  ""        if non-empty, $readmemh preload at time 0
// PORTS
// clk          in     1       system clock
// rst          in     1       asynchronous reset, active-low
// SRAM_DQ      inout  16      data bus; model drives only during a read
// SRAM_ADDR    in     ADDR_W  halfword address
// SRAM_UB_N    in     1       high-byte mask, active-low
// SRAM_LB_N    in     1       low-byte mask, active-low
// SRAM_WE_N    in     1       write enable, active-low
// SRAM_CE_N    in     1       chip enable, active-low
// SRAM_OE_N    in     1       output enable, active-low
// rd_count     out    32      completed read accesses (per clk edge)
// wr_count     out    32      completed write accesses (per clk edge)
// err_contend  out    1       sticky: WE_N low while the model drove DQ
// err_range    out    1       sticky: access with SRAM_ADDR >= DEPTH
// BEHAVIOUR
// - Reset (rst=0, async): rd_count=0, wr_count=0, err_*=0, read pipeline emptied, DQ released (Z).
//   Memory contents are NOT cleared; they survive reset.
// - Cycle classification, from the pins sampled at each posedge clk:
//   - WRITE: CE_N=0 & WE_N=0.
//   - READ: CE_N=0 & WE_N=1 & OE_N=0.
//   - IDLE: anything else.
// - WRITE: at the edge, mem[ADDR][15:8] <= DQ[15:8] if UB_N=0; mem[ADDR][7:0] <= DQ[7:0] if LB_N=0.
//   - wr_count+1, including the case where both lanes are masked.
//   - WE_N overrides OE_N.
// - READ, READ_LAT=0:
//   - DQ = mem[ADDR] combinationally while the READ condition holds on the live pins; Z otherwise.
//   - rd_count+1 at each edge in READ.
//   - Controller timing: ADDR set at edge k, DQ sampled at edge k+1, which returns mem[ADDR at k].
// - READ, READ_LAT=N>=1:
//   - The address is captured at the edge; data goes through an N-deep shift register {valid, data}.
//   - DQ is driven with the data from the last pipeline stage while its valid bit is 1 and OE_N=0; Z otherwise.
//   - rd_count increments when a valid stage exits the pipeline.
//   - Back-to-back reads stream one word per clk.
// - Byte lanes on read: a lane whose mask is 1 is Z.
// - Read-after-write to the same address in consecutive cycles returns the newly written data (write-first).
// - Simultaneous events:
//   - A WRITE while the read pipeline holds valid data: the pipeline entries still retire and are counted.
//   - If the model would be driving DQ in that cycle, it does not drive; err_contend is set.
// - Range errors:
//   - ADDR >= DEPTH in READ or WRITE sets err_range.
//   - Writes are dropped; reads return 16'hxxxx.
// - Counters wrap modulo 2**32. Error flags clear only on reset.
// - Reset mid-burst: the pipeline is flushed, DQ goes Z immediately, and a pending write at that edge is not committed.
// TESTING
// 1. Write 0x1234 @5, then 0xABCD @6 (UB=LB=0), then 4-cycle controller read @4..7 (LAT=0):
//    -> DQ reads X,0x1234,0xABCD,X; wr_count=2, rd_count=4.
// 2. Byte mask: write 0xFFFF @9, then write 0x0000 @9 with UB_N=1:
//    -> read @9 = 0xFF00; read with LB_N=1 -> DQ[7:0]=Z.
// 3. READ_LAT=2, reads @0,1,2 back-to-back (preloaded 0x10,0x11,0x12):
//    -> DQ = 0x10,0x11,0x12 on edges 2,3,4; then Z.
// 4. Contention: LAT=2 read issued, WE_N=0 one cycle later -> err_contend=1 and the model does not drive DQ.
//    Result stays 1 until rst=0.
// 5. DEPTH=1024, write @1024 -> err_range=1, mem unchanged; wr_count still +1.
// 6. Assert rst low mid-pipeline (LAT=2) -> DQ=Z same cycle, counters 0, mem @5 still 0x1234.

Source files
------------

// File: rtl/sram_chip_model.sv
// Responder model of a 16-bit async board SRAM: stores halfwords, returns reads after READ_LAT edges
// (0 = combinational), counts accesses and flags contention / out-of-range accesses; no backpressure.
module sram_chip_model #(
  parameter int    ADDR_W    = 18,
  parameter int    DEPTH     = 262144,
  parameter int    READ_LAT  = 0,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [15:0]       SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic              err_contend,
  output logic              err_range
);

  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic          wr_cyc;
  logic          rd_cyc;
  logic          in_range;
  logic [MW-1:0] idx;
  logic [15:0]   rd_word;
  logic          rd_retire;
  logic          contend_set;
  logic          drv_hi;
  logic          drv_lo;
  logic [15:0]   dq_out;

  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;
  logic        err_contend_q, err_contend_d;
  logic        err_range_q, err_range_d;

  assign wr_cyc   = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_cyc   = !SRAM_CE_N && SRAM_WE_N && !SRAM_OE_N;
  assign in_range = {1'b0, SRAM_ADDR} < DEPTH_L;
  assign idx      = SRAM_ADDR[MW-1:0];
  assign rd_word  = in_range ? mem[idx] : 16'hxxxx;

  // Contents survive reset; only a write at an edge with reset deasserted commits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
    end else if (wr_cyc && in_range) begin
      if (!SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
    end
  end

  if (READ_LAT == 0) begin : g_async
    assign rd_retire   = rd_cyc;
    assign contend_set = 1'b0;
    assign drv_hi      = rst && rd_cyc && !SRAM_UB_N;
    assign drv_lo      = rst && rd_cyc && !SRAM_LB_N;
    assign dq_out      = rd_word;
  end else begin : g_pipe
    logic [READ_LAT-1:0] vld_q, vld_d;
    logic [15:0]         dat_q [READ_LAT];
    logic [15:0]         dat_d [READ_LAT];
    logic                would_drive;

    always_comb begin
      vld_d[0] = rd_cyc;
      dat_d[0] = rd_word;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_q <= '0;
      else      vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
      dat_q <= dat_d;
    end

    // A controller driving WE_N low wins the bus; the model backs off and records it.
    assign would_drive = rst && vld_q[READ_LAT-1] && !SRAM_OE_N;
    assign contend_set = would_drive && !SRAM_WE_N;
    assign drv_hi      = would_drive && SRAM_WE_N && !SRAM_UB_N;
    assign drv_lo      = would_drive && SRAM_WE_N && !SRAM_LB_N;
    assign rd_retire   = vld_q[READ_LAT-1];
    assign dq_out      = dat_q[READ_LAT-1];
  end

  assign SRAM_DQ[15:8] = drv_hi ? dq_out[15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = drv_lo ? dq_out[7:0]  : 8'hzz;

  always_comb begin
    wr_count_d    = wr_count_q + (wr_cyc ? 32'd1 : 32'd0);
    rd_count_d    = rd_count_q + (rd_retire ? 32'd1 : 32'd0);
    err_range_d   = err_range_q | ((wr_cyc | rd_cyc) & !in_range);
    err_contend_d = err_contend_q | contend_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_q    <= '0;
      wr_count_q    <= '0;
      err_contend_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      rd_count_q    <= rd_count_d;
      wr_count_q    <= wr_count_d;
      err_contend_q <= err_contend_d;
      err_range_q   <= err_range_d;
    end
  end

  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;
  assign err_contend = err_contend_q;
  assign err_range   = err_range_q;

endmodule
